cmd_port_arbiter: RTL and testbench

- Shares the sequencer command port (cmd_data / latch_data into system_controller) among NUM_REQ command sources, e.g. the Wishbone host and the logic-analyzer probe path.
- Accepts 32-bit commands through valid/ready handshakes and picks sources round-robin.
- Buffers accepted commands in a small FIFO.
- Replays each command as a stable cmd_data word with a timed latch_data pulse. Every command produces exactly one rising edge for the downstream impulse detector.

---
 rtl/cmd_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_cmd_port_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_port_arbiter.sv
// cmd_port_arbiter: round-robin arbitration of NUM_REQ command sources into
// a small command FIFO, replayed to system_controller as a stable cmd_data
// word with a latch_data pulse of HOLD_CYCLES high and GAP_CYCLES low.
module cmd_port_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [32*NUM_REQ-1:0]        req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         flush,
  output logic [31:0]                  cmd_data,
  output logic                         latch_data,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         busy
);

  localparam int CW   = $clog2(DEPTH+1);
  localparam int PW   = $clog2(DEPTH);
  localparam int GW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [31:0]     cmd_q, cmd_d;
  logic            latch_q, latch_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     fifo_mem [DEPTH];

  logic            can_accept;
  logic            grant_found;
  logic [GW-1:0]   grant_idx;
  logic [GW-1:0]   cand;
  logic            push;
  logic            pop;

  // Round-robin search starting just after the last granted source; a full
  // FIFO is never ready, even in a cycle where it pops (no bypass path).
  always_comb begin
    can_accept  = !flush && (count_q < CW'(DEPTH));
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    req_ready = '0;
    if (can_accept && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign push = can_accept && grant_found;
  assign pop  = (state_q == ST_IDLE) && (count_q != '0) && !flush;

  // FIFO pointers, occupancy and round-robin pointer; flush overrides push/pop.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d     = wr_ptr_q + 1'b1;
        last_grant_d = grant_idx;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Command storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= req_data[32*grant_idx +: 32];
    end
  end

  // Sequencer: pop in IDLE, hold the strobe high in DRIVE, enforce low time in GAP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    latch_d = latch_q;
    case (state_q)
      ST_IDLE: begin
        latch_d = 1'b0;
        if (pop) begin
          cmd_d   = fifo_mem[rd_ptr_q];
          latch_d = 1'b1;
          cnt_d   = TW'(HOLD_CYCLES - 1);
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        latch_d = 1'b1;
        if (cnt_q == '0) begin
          latch_d = 1'b0;
          cnt_d   = TW'(GAP_CYCLES - 1);
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        latch_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        latch_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset drops the strobe at once and discards the queue.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cmd_q        <= '0;
      latch_q      <= 1'b0;
      last_grant_q <= GW'(NUM_REQ - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      latch_q      <= latch_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign cmd_data   = cmd_q;
  assign latch_data = latch_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != ST_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_cmd_port_arbiter.sv
// Testbench for cmd_port_arbiter: directed scenarios on a default instance,
// a 3-source / 1-high / 3-low instance, and a randomized run against a
// queue-based reference model.
module tb_cmd_port_arbiter;

  localparam int NA = 2;
  localparam int DA = 4;
  localparam int HA = 2;
  localparam int GA = 2;

  logic        clock = 1'b0;
  logic        reset_n;

  logic [1:0]  valid_a;
  logic [63:0] data_a;
  logic [1:0]  ready_a;
  logic        flush_a;
  logic [31:0] cmd_a;
  logic        latch_a;
  logic [2:0]  count_a;
  logic        busy_a;

  logic [2:0]  valid_b;
  logic [95:0] data_b;
  logic [2:0]  ready_b;
  logic        flush_b;
  logic [31:0] cmd_b;
  logic        latch_b;
  logic [2:0]  count_b;
  logic        busy_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  cmd_port_arbiter #(.NUM_REQ(NA), .DEPTH(DA), .HOLD_CYCLES(HA), .GAP_CYCLES(GA)) dut_a (
    .clock(clock), .reset_n(reset_n), .req_valid(valid_a), .req_data(data_a),
    .req_ready(ready_a), .flush(flush_a), .cmd_data(cmd_a), .latch_data(latch_a),
    .fifo_count(count_a), .busy(busy_a)
  );

  cmd_port_arbiter #(.NUM_REQ(3), .DEPTH(4), .HOLD_CYCLES(1), .GAP_CYCLES(3)) dut_b (
    .clock(clock), .reset_n(reset_n), .req_valid(valid_b), .req_data(data_b),
    .req_ready(ready_b), .flush(flush_b), .cmd_data(cmd_b), .latch_data(latch_b),
    .fifo_count(count_b), .busy(busy_b)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (default instance) ----------------
  logic [31:0] m_q[$];
  int          m_lg;
  int          m_age;
  logic [31:0] m_cmd;

  task automatic model_reset();
    m_q.delete();
    m_lg  = NA - 1;
    m_age = 1000;
    m_cmd = 32'h0;
  endtask

  function automatic int model_pick(input logic [1:0] v, input logic f);
    if (f || m_q.size() >= DA) return -1;
    for (int k = 1; k <= NA; k++) begin
      int s;
      s = (m_lg + k) % NA;
      if (v[s]) return s;
    end
    return -1;
  endfunction

  task automatic model_tick(input logic [1:0] v, input logic [63:0] d, input logic f);
    int g;
    bit pop;
    g   = model_pick(v, f);
    pop = !f && (m_q.size() != 0) && (m_age >= HA + GA + 1);
    if (pop) m_cmd = m_q.pop_front();
    if (f) m_q.delete();
    else if (g >= 0) begin
      m_q.push_back(d[32*g +: 32]);
      m_lg = g;
    end
    m_age = pop ? 1 : ((m_age < 1000) ? m_age + 1 : m_age);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    valid_a = '0; data_a = '0; flush_a = 1'b0;
    valid_b = '0; data_b = '0; flush_b = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    reset_n = 1'b0;
    @(negedge clock);
    checks++; if (cmd_a !== 32'h0) begin errors++; $display("FAIL reset_cmd: got %h expected %h", cmd_a, 32'h0); end
    checks++; if (latch_a !== 1'b0) begin errors++; $display("FAIL reset_latch: got %b expected 0", latch_a); end
    checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    valid_a = 2'b11;
    @(negedge clock);
    checks++; if (ready_a !== 2'b01) begin errors++; $display("FAIL reset_first_grant: got %b expected 01", ready_a); end
    @(posedge clock); #1;
    valid_a = '0;
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [31:0] w;
    logic        el, eb;
    logic [2:0]  ec;
    w = 32'h8000_1234;
    apply_reset();
    valid_a = 2'b01;
    data_a  = {32'h0, w};
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      el = (c == 2 || c == 3);
      eb = (c >= 1 && c <= 5);
      ec = (c == 1) ? 3'd1 : 3'd0;
      if (c == 0) begin
        checks++; if (ready_a !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", ready_a); end
      end
      checks++; if (count_a !== ec) begin errors++; $display("FAIL single_count c%0d: got %0d expected %0d", c, count_a, ec); end
      checks++; if (latch_a !== el) begin errors++; $display("FAIL single_latch c%0d: got %b expected %b", c, latch_a, el); end
      checks++; if (busy_a !== eb) begin errors++; $display("FAIL single_busy c%0d: got %b expected %b", c, busy_a, eb); end
      if (c >= 2) begin
        checks++; if (cmd_a !== w) begin errors++; $display("FAIL single_cmd c%0d: got %h expected %h", c, cmd_a, w); end
      end
      @(posedge clock); #1;
      if (c == 0) valid_a = '0;
    end
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    logic [31:0] got[$];
    int          edge_cyc[$];
    int          ia, ib;
    logic        prev, r0, r1;
    logic [31:0] exp_w;
    apply_reset();
    ia = 0; ib = 0; prev = 1'b0;
    for (int c = 0; c < 80; c++) begin
      valid_a = {(ib < 3), (ia < 3)};
      data_a  = {32'hB000_0000 + 32'(ib), 32'hA000_0000 + 32'(ia)};
      @(negedge clock);
      if (latch_a && !prev) begin got.push_back(cmd_a); edge_cyc.push_back(cyc); end
      prev = latch_a;
      r0 = ready_a[0]; r1 = ready_a[1];
      @(posedge clock); #1;
      if (r0) ia++;
      if (r1) ib++;
      if (got.size() == 6) break;
    end
    valid_a = '0;
    checks++; if (got.size() != 6) begin errors++; $display("FAIL rr_count: got %0d commands expected 6", got.size()); end
    for (int k = 0; k < got.size() && k < 6; k++) begin
      exp_w = (k % 2 == 0) ? 32'hA000_0000 + 32'(k/2) : 32'hB000_0000 + 32'(k/2);
      checks++; if (got[k] !== exp_w) begin errors++; $display("FAIL rr_order %0d: got %h expected %h", k, got[k], exp_w); end
      if (k > 0) begin
        checks++; if (edge_cyc[k] - edge_cyc[k-1] != 5) begin errors++; $display("FAIL rr_period %0d: got %0d expected 5", k, edge_cyc[k] - edge_cyc[k-1]); end
      end
    end
    $display("test_round_robin done");
  endtask

  task automatic test_fill();
    logic [31:0] got[$];
    int          i;
    int          issued_at_full;
    logic        prev, r0;
    apply_reset();
    i = 0; prev = 1'b0; issued_at_full = -1;
    for (int c = 0; c < 120; c++) begin
      valid_a = {1'b0, (i < 6)};
      data_a  = {32'h0, 32'hF00D_0000 + 32'(i)};
      @(negedge clock);
      if (latch_a && !prev) got.push_back(cmd_a);
      prev = latch_a;
      if (count_a == 3'd4) begin
        if (issued_at_full < 0) issued_at_full = got.size();
        checks++; if (ready_a !== 2'b00) begin errors++; $display("FAIL fill_full_ready: got %b expected 00", ready_a); end
      end else if (i < 6) begin
        checks++; if (ready_a !== 2'b01) begin errors++; $display("FAIL fill_ready: got %b expected 01", ready_a); end
      end
      r0 = ready_a[0];
      @(posedge clock); #1;
      if (r0) i++;
      if (got.size() == 6 && i == 6) break;
    end
    valid_a = '0;
    checks++; if (issued_at_full != 1) begin errors++; $display("FAIL fill_issued_at_full: got %0d expected 1", issued_at_full); end
    checks++; if (got.size() != 6) begin errors++; $display("FAIL fill_count: got %0d commands expected 6", got.size()); end
    for (int k = 0; k < got.size() && k < 6; k++) begin
      checks++; if (got[k] !== 32'hF00D_0000 + 32'(k)) begin errors++; $display("FAIL fill_order %0d: got %h expected %h", k, got[k], 32'hF00D_0000 + 32'(k)); end
    end
    $display("test_fill done");
  endtask

  task automatic test_flush();
    logic        el, eb;
    logic [2:0]  ec;
    logic [31:0] c0;
    c0 = 32'hC0DE_0000;
    apply_reset();
    for (int c = 0; c < 26; c++) begin
      valid_a = {1'b0, (c < 3)};
      data_a  = {32'h0, c0 + 32'(c)};
      flush_a = (c == 3);
      @(negedge clock);
      el = (c == 2 || c == 3);
      eb = (c >= 1 && c <= 5);
      ec = (c == 1 || c == 2) ? 3'd1 : ((c == 3) ? 3'd2 : 3'd0);
      checks++; if (latch_a !== el) begin errors++; $display("FAIL flush_latch c%0d: got %b expected %b", c, latch_a, el); end
      checks++; if (count_a !== ec) begin errors++; $display("FAIL flush_count c%0d: got %0d expected %0d", c, count_a, ec); end
      checks++; if (busy_a !== eb) begin errors++; $display("FAIL flush_busy c%0d: got %b expected %b", c, busy_a, eb); end
      if (c >= 2) begin
        checks++; if (cmd_a !== c0) begin errors++; $display("FAIL flush_cmd c%0d: got %h expected %h", c, cmd_a, c0); end
      end
      if (c == 3) begin
        checks++; if (ready_a !== 2'b00) begin errors++; $display("FAIL flush_ready: got %b expected 00", ready_a); end
      end
      @(posedge clock); #1;
    end
    flush_a = 1'b0;
    valid_a = '0;
    $display("test_flush done");
  endtask

  task automatic test_reset_mid_pulse();
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      valid_a = {1'b0, (c < 2)};
      data_a  = {32'h0, 32'hD000_0000 + 32'(c)};
      @(negedge clock);
      if (c == 3) begin
        checks++; if (latch_a !== 1'b1) begin errors++; $display("FAIL midrst_pre_latch: got %b expected 1", latch_a); end
        checks++; if (count_a !== 3'd1) begin errors++; $display("FAIL midrst_pre_count: got %0d expected 1", count_a); end
      end else begin
        @(posedge clock); #1;
      end
    end
    valid_a = '0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (latch_a !== 1'b0) begin errors++; $display("FAIL midrst_latch: got %b expected 0", latch_a); end
    checks++; if (cmd_a !== 32'h0) begin errors++; $display("FAIL midrst_cmd: got %h expected 0", cmd_a); end
    checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", count_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy_a); end
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    valid_a = 2'b11;
    @(negedge clock);
    checks++; if (ready_a !== 2'b01) begin errors++; $display("FAIL midrst_first_grant: got %b expected 01", ready_a); end
    checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL midrst_post_count: got %0d expected 0", count_a); end
    @(posedge clock); #1;
    valid_a = '0;
    $display("test_reset_mid_pulse done");
  endtask

  task automatic test_three_sources();
    logic [31:0] e_words[4];
    logic [31:0] got[$];
    int          edge_cyc[$];
    int          j;
    logic        prev, r2;
    apply_reset();
    for (int k = 0; k < 4; k++) e_words[k] = $urandom;
    j = 0; prev = 1'b0;
    for (int c = 0; c < 100; c++) begin
      valid_b = {(j < 4), 2'b00};
      data_b  = {e_words[(j < 4) ? j : 3], $urandom, $urandom};
      @(negedge clock);
      if (j < 4) begin
        checks++; if (ready_b !== 3'b100) begin errors++; $display("FAIL three_ready c%0d: got %b expected 100", c, ready_b); end
      end
      if (prev) begin
        checks++; if (latch_b !== 1'b0) begin errors++; $display("FAIL three_hold c%0d: got %b expected 0", c, latch_b); end
      end
      if (latch_b && !prev) begin got.push_back(cmd_b); edge_cyc.push_back(cyc); end
      prev = latch_b;
      r2 = ready_b[2];
      @(posedge clock); #1;
      if (r2) j++;
      if (got.size() == 4) break;
    end
    valid_b = '0;
    checks++; if (got.size() != 4) begin errors++; $display("FAIL three_count: got %0d commands expected 4", got.size()); end
    for (int k = 0; k < got.size() && k < 4; k++) begin
      checks++; if (got[k] !== e_words[k]) begin errors++; $display("FAIL three_word %0d: got %h expected %h", k, got[k], e_words[k]); end
      checks++; if ({got[k][31:30], got[k][29:26]} !== {e_words[k][31:30], e_words[k][29:26]}) begin
        errors++; $display("FAIL three_fields %0d: got %b_%b expected %b_%b", k, got[k][31:30], got[k][29:26], e_words[k][31:30], e_words[k][29:26]);
      end
      if (k > 0) begin
        checks++; if (edge_cyc[k] - edge_cyc[k-1] != 5) begin errors++; $display("FAIL three_period %0d: got %0d expected 5", k, edge_cyc[k] - edge_cyc[k-1]); end
      end
    end
    $display("test_three_sources done");
  endtask

  task automatic test_random();
    int          g;
    logic [1:0]  er;
    logic        el, eb;
    logic [2:0]  ec;
    apply_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      valid_a = 2'($urandom_range(0, 3));
      data_a  = {$urandom, $urandom};
      flush_a = ($urandom_range(0, 15) == 0);
      @(negedge clock);
      g  = model_pick(valid_a, flush_a);
      er = (g < 0) ? 2'b00 : (2'b01 << g);
      el = (m_age >= 1) && (m_age <= HA);
      eb = (m_q.size() != 0) || (m_age <= HA + GA);
      ec = 3'(m_q.size());
      checks++; if (ready_a !== er) begin errors++; $display("FAIL rand_ready c%0d: got %b expected %b", c, ready_a, er); end
      checks++; if (latch_a !== el) begin errors++; $display("FAIL rand_latch c%0d: got %b expected %b", c, latch_a, el); end
      checks++; if (cmd_a !== m_cmd) begin errors++; $display("FAIL rand_cmd c%0d: got %h expected %h", c, cmd_a, m_cmd); end
      checks++; if (count_a !== ec) begin errors++; $display("FAIL rand_count c%0d: got %0d expected %0d", c, count_a, ec); end
      checks++; if (busy_a !== eb) begin errors++; $display("FAIL rand_busy c%0d: got %b expected %b", c, busy_a, eb); end
      model_tick(valid_a, data_a, flush_a);
      @(posedge clock); #1;
    end
    valid_a = '0;
    flush_a = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fill();
    test_flush();
    test_reset_mid_pulse();
    test_three_sources();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
